// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared encodings, record types and helpers for the hazard controller
// Purpose: forwarding-select encodings, the Tuse "never" marker, mult/div latency defaults,
// shadow-pipeline record layouts and the input normalisation helpers.
package hazard_ctrl_pkg;

    localparam int REG_AW       = 5;
    localparam int TNEW_W       = 2;
    localparam int TUSE_NEVER   = 4;
    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    // D-stage selects: register file, or the E/M/W producer.
    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    // E-stage selects: value latched in DE, or the M/W producer.
    localparam logic [1:0] FWD_E_DE = 2'd0;
    localparam logic [1:0] FWD_E_M  = 2'd1;
    localparam logic [1:0] FWD_E_W  = 2'd2;

    // Producer view of a stage (M and W only need this much).
    typedef struct packed {
        logic [REG_AW-1:0] a3;
        logic [TNEW_W-1:0] tnew;
    } prod_rec_t;

    // E additionally keeps its own read addresses for E-stage forwarding.
    typedef struct packed {
        logic [REG_AW-1:0] a3;
        logic [TNEW_W-1:0] tnew;
        logic [REG_AW-1:0] a1;
        logic [REG_AW-1:0] a2;
    } e_rec_t;

    // Anything outside 1..31 (0, -2, wide values) means "no register".
    function automatic logic [REG_AW-1:0] norm_addr(input logic [31:0] a);
        return (a >= 32'd1 && a <= 32'd31) ? a[REG_AW-1:0] : '0;
    endfunction

    // Saturating decrement of a decoder Tnew, clamped to the record width.
    function automatic logic [TNEW_W-1:0] sat_tnew(input logic [31:0] t);
        if (t == 32'd0) return '0;
        if (t > 32'd4) return 2'd3;
        return 2'(t - 32'd1);
    endfunction

    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
        return (t != '0) ? t - 2'd1 : '0;
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_cnt.sv
// rtl/hazard_ctrl_md_busy_cnt.sv - mult/div busy counter
// Purpose: loads MULT_CYC/DIV_CYC on a start pulse, then counts down to zero.
// Ports: clk_i (clock), rst_n_i (async active-low clear), start_i (mult/div start pulse),
//        div_i (1 = div latency), busy_o (counter nonzero).
module md_busy_cnt
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic start_i,
    input  logic div_i,
    output logic busy_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A start while still busy simply reloads; the core cannot issue one from an unstalled D.
    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = div_i ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall and forwarding controller for the 5-stage core
// Purpose: tracks producer records for E/M/W, raises stall on unresolved RAW or HI/LO
// hazards and drives the D/E forwarding mux selects.
// Ports: clk, reset (async active-low); D_* hazard fields of the instruction in D;
//        md_start/md_div (E-stage mult/div start); stall; fwd_D_A{1,2}_sel (0 RF,1 E,2 M,3 W);
//        fwd_E_A{1,2}_sel (0 DE,1 M,2 W); md_busy.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] D_A1,
    input  logic [31:0] D_A2,
    input  logic [31:0] D_Tuse_A1,
    input  logic [31:0] D_Tuse_A2,
    input  logic [31:0] D_A3,
    input  logic [31:0] D_Tnew,
    input  logic        D_is_md,
    input  logic        md_start,
    input  logic        md_div,
    output logic        stall,
    output logic [1:0]  fwd_D_A1_sel,
    output logic [1:0]  fwd_D_A2_sel,
    output logic [1:0]  fwd_E_A1_sel,
    output logic [1:0]  fwd_E_A2_sel,
    output logic        md_busy
);

    logic [REG_AW-1:0] d_a1, d_a2, d_a3;
    e_rec_t            e_q, e_d;
    prod_rec_t         m_q, m_d, w_q, w_d, e_prod;
    logic              stall_rs, stall_rt, stall_md;

    // Read hazard: the value will not exist by the time the reader consumes it.
    function automatic logic rd_hazard(input logic [REG_AW-1:0] a, input logic [31:0] tuse,
                                       input prod_rec_t e, input prod_rec_t m);
        return (a != '0) && (tuse < 32'(TUSE_NEVER)) &&
               ((e.a3 == a && 32'(e.tnew) > tuse) || (m.a3 == a && 32'(m.tnew) > tuse));
    endfunction

    // Only the newest matching producer is considered; an older stage holds a stale value.
    function automatic logic [1:0] sel_d(input logic [REG_AW-1:0] a, input prod_rec_t e,
                                         input prod_rec_t m, input prod_rec_t w);
        if (a == '0)   return FWD_RF;
        if (e.a3 == a) return (e.tnew == '0) ? FWD_E : FWD_RF;
        if (m.a3 == a) return (m.tnew == '0) ? FWD_M : FWD_RF;
        if (w.a3 == a) return (w.tnew == '0) ? FWD_W : FWD_RF;
        return FWD_RF;
    endfunction

    function automatic logic [1:0] sel_e(input logic [REG_AW-1:0] a, input prod_rec_t m,
                                         input prod_rec_t w);
        if (a == '0)   return FWD_E_DE;
        if (m.a3 == a) return (m.tnew == '0) ? FWD_E_M : FWD_E_DE;
        if (w.a3 == a) return (w.tnew == '0) ? FWD_E_W : FWD_E_DE;
        return FWD_E_DE;
    endfunction

    assign d_a1   = norm_addr(D_A1);
    assign d_a2   = norm_addr(D_A2);
    assign d_a3   = norm_addr(D_A3);
    assign e_prod = '{a3: e_q.a3, tnew: e_q.tnew};

    md_busy_cnt #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC),
        .CNT_W    (CNT_W)
    ) u_md_busy_cnt (
        .clk_i   (clk),
        .rst_n_i (reset),
        .start_i (md_start),
        .div_i   (md_div),
        .busy_o  (md_busy)
    );

    assign stall_rs = rd_hazard(d_a1, D_Tuse_A1, e_prod, m_q);
    assign stall_rt = rd_hazard(d_a2, D_Tuse_A2, e_prod, m_q);
    // md_start counts as busy in its own cycle so a HI/LO user right behind it waits.
    assign stall_md = D_is_md && (md_start || md_busy);
    assign stall    = stall_rs | stall_rt | stall_md;

    assign fwd_D_A1_sel = sel_d(d_a1, e_prod, m_q, w_q);
    assign fwd_D_A2_sel = sel_d(d_a2, e_prod, m_q, w_q);
    assign fwd_E_A1_sel = sel_e(e_q.a1, m_q, w_q);
    assign fwd_E_A2_sel = sel_e(e_q.a2, m_q, w_q);

    // M and W always advance; only E takes a bubble on stall.
    always_comb begin
        e_d = '0;
        if (!stall) begin
            e_d = '{a3: d_a3, tnew: sat_tnew(D_Tnew), a1: d_a1, a2: d_a2};
        end
        m_d = '{a3: e_q.a3, tnew: sat_dec(e_q.tnew)};
        w_d = '{a3: m_q.a3, tnew: sat_dec(m_q.tnew)};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] D_A1, D_A2, D_Tuse_A1, D_Tuse_A2, D_A3, D_Tnew;
    logic        D_is_md, md_start, md_div;
    logic        stall, md_busy;
    logic [1:0]  fwd_D_A1_sel, fwd_D_A2_sel, fwd_E_A1_sel, fwd_E_A2_sel;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .D_A1         (D_A1),
        .D_A2         (D_A2),
        .D_Tuse_A1    (D_Tuse_A1),
        .D_Tuse_A2    (D_Tuse_A2),
        .D_A3         (D_A3),
        .D_Tnew       (D_Tnew),
        .D_is_md      (D_is_md),
        .md_start     (md_start),
        .md_div       (md_div),
        .stall        (stall),
        .fwd_D_A1_sel (fwd_D_A1_sel),
        .fwd_D_A2_sel (fwd_D_A2_sel),
        .fwd_E_A1_sel (fwd_E_A1_sel),
        .fwd_E_A2_sel (fwd_E_A2_sel),
        .md_busy      (md_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [31:0] a1, input logic [31:0] tu1, input logic [31:0] a2,
                         input logic [31:0] tu2, input logic [31:0] a3, input logic [31:0] tn);
        D_A1 = a1; D_Tuse_A1 = tu1; D_A2 = a2; D_Tuse_A2 = tu2; D_A3 = a3; D_Tnew = tn;
        #1;
    endtask

    task automatic nop();
        set_d(0, 4, 0, 4, 0, 0);
    endtask

    task automatic flush();
        repeat (3) begin nop(); step(); end
    endtask

    task automatic test_reset();
        reset = 1'b0; D_is_md = 1'b0; md_start = 1'b0; md_div = 1'b0;
        nop();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b exp 0", stall); end
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", md_busy); end
        checks++;
        if ({fwd_D_A1_sel, fwd_D_A2_sel, fwd_E_A1_sel, fwd_E_A2_sel} !== 8'h00) begin
            errors++;
            $display("FAIL rst_sels: got %h exp 00", {fwd_D_A1_sel, fwd_D_A2_sel, fwd_E_A1_sel, fwd_E_A2_sel});
        end
        D_is_md = 1'b1; md_start = 1'b1; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_md_stall: got %b exp 1", stall); end
        D_is_md = 1'b0; md_start = 1'b0; #1;
        reset = 1'b1;
        step();
    endtask

    task automatic test_alu_fwd();
        set_d(0, 4, 0, 4, 3, 2);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall0: got %b exp 0", stall); end
        step();
        set_d(3, 1, 0, 4, 4, 2);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall1: got %b exp 0", stall); end
        checks++; if (fwd_D_A1_sel !== 2'd0) begin errors++; $display("FAIL alu_fwdD: got %0d exp 0", fwd_D_A1_sel); end
        step();
        nop();
        checks++; if (fwd_E_A1_sel !== 2'd1) begin errors++; $display("FAIL alu_fwdE1: got %0d exp 1", fwd_E_A1_sel); end
        checks++; if (fwd_E_A2_sel !== 2'd0) begin errors++; $display("FAIL alu_fwdE2: got %0d exp 0", fwd_E_A2_sel); end
        step();
        flush();
    endtask

    task automatic test_load_use();
        set_d(0, 4, 0, 4, 5, 3);
        step();
        set_d(5, 1, 0, 4, 6, 2);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall1: got %b exp 1", stall); end
        step();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall2: got %b exp 0", stall); end
        checks++; if (fwd_D_A1_sel !== 2'd0) begin errors++; $display("FAIL lu_fwdD: got %0d exp 0", fwd_D_A1_sel); end
        step();
        nop();
        checks++; if (fwd_E_A1_sel !== 2'd2) begin errors++; $display("FAIL lu_fwdE: got %0d exp 2", fwd_E_A1_sel); end
        step();
        flush();
    endtask

    task automatic test_load_branch();
        set_d(0, 4, 0, 4, 5, 3);
        step();
        set_d(5, 0, 5, 0, 0, 0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lb_stall1: got %b exp 1", stall); end
        step();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lb_stall2: got %b exp 1", stall); end
        step();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lb_stall3: got %b exp 0", stall); end
        checks++; if (fwd_D_A1_sel !== 2'd3) begin errors++; $display("FAIL lb_fwdD1: got %0d exp 3", fwd_D_A1_sel); end
        checks++; if (fwd_D_A2_sel !== 2'd3) begin errors++; $display("FAIL lb_fwdD2: got %0d exp 3", fwd_D_A2_sel); end
        step();
        flush();
    endtask

    task automatic test_jal_zero();
        set_d(0, 4, 0, 4, 31, 1);
        step();
        set_d(31, 0, 0, 4, 0, 0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL jr_stall: got %b exp 0", stall); end
        checks++; if (fwd_D_A1_sel !== 2'd1) begin errors++; $display("FAIL jr_fwdD: got %0d exp 1", fwd_D_A1_sel); end
        step();
        set_d(0, 4, 0, 4, 0, 3);
        step();
        set_d(0, 0, 0, 0, 0, 0);
        checks++; if ({stall, fwd_D_A1_sel, fwd_D_A2_sel} !== 5'd0) begin
            errors++; $display("FAIL zero_rd: got %b exp 00000", {stall, fwd_D_A1_sel, fwd_D_A2_sel});
        end
        step();
        // -2 must not alias onto $30
        set_d(0, 4, 0, 4, 32'hFFFF_FFFE, 3);
        step();
        set_d(30, 0, 0, 4, 0, 0);
        checks++; if ({stall, fwd_D_A1_sel} !== 3'd0) begin
            errors++; $display("FAIL neg2_alias: got %b exp 000", {stall, fwd_D_A1_sel});
        end
        step();
        // 35 must not alias onto $3
        set_d(0, 4, 0, 4, 32'd35, 1);
        step();
        set_d(3, 0, 0, 4, 0, 0);
        checks++; if ({stall, fwd_D_A1_sel} !== 3'd0) begin
            errors++; $display("FAIL wide_alias: got %b exp 000", {stall, fwd_D_A1_sel});
        end
        step();
        flush();
    endtask

    task automatic test_tuse_never();
        set_d(0, 4, 0, 4, 8, 1);
        step();
        set_d(0, 4, 8, 4, 0, 0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL tn_stall: got %b exp 0", stall); end
        checks++; if (fwd_D_A2_sel !== 2'd1) begin errors++; $display("FAIL tn_fwd: got %0d exp 1", fwd_D_A2_sel); end
        step();
        flush();
        set_d(0, 4, 0, 4, 7, 3);
        step();
        set_d(7, 4, 0, 4, 0, 0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL tn_lw_stall: got %b exp 0", stall); end
        step();
        flush();
        // newest producer of $9 is not ready; the ready older one must not be picked
        set_d(0, 4, 0, 4, 9, 2);
        step();
        set_d(0, 4, 0, 4, 9, 3);
        step();
        set_d(9, 4, 9, 4, 0, 0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nft_stall: got %b exp 0", stall); end
        checks++; if (fwd_D_A1_sel !== 2'd0) begin errors++; $display("FAIL nft_fwd1: got %0d exp 0", fwd_D_A1_sel); end
        checks++; if (fwd_D_A2_sel !== 2'd0) begin errors++; $display("FAIL nft_fwd2: got %0d exp 0", fwd_D_A2_sel); end
        step();
        flush();
    endtask

    task automatic test_md();
        for (int k = 0; k < 2; k++) begin
            int n;
            n = (k == 1) ? 10 : 5;
            nop();
            D_is_md = 1'b1; md_start = 1'b1; md_div = (k == 1); #1;
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL md%0d_start_stall: got %b exp 1", k, stall); end
            checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL md%0d_start_busy: got %b exp 0", k, md_busy); end
            step();
            md_start = 1'b0; #1;
            for (int i = 0; i < n; i++) begin
                checks++;
                if ({stall, md_busy} !== 2'b11) begin
                    errors++; $display("FAIL md%0d_busy_c%0d: got %b exp 11", k, i, {stall, md_busy});
                end
                step();
            end
            checks++;
            if ({stall, md_busy} !== 2'b00) begin
                errors++; $display("FAIL md%0d_done: got %b exp 00", k, {stall, md_busy});
            end
            D_is_md = 1'b0;
            step();
        end
    endtask

    task automatic test_reset_mid();
        nop();
        D_is_md = 1'b1; md_div = 1'b1; md_start = 1'b1; #1;
        step();
        md_start = 1'b0;
        step(); step(); #1;
        checks++; if ({stall, md_busy} !== 2'b11) begin errors++; $display("FAIL rm_busy: got %b exp 11", {stall, md_busy}); end
        reset = 1'b0; #1;
        checks++; if ({stall, md_busy} !== 2'b00) begin errors++; $display("FAIL rm_clear: got %b exp 00", {stall, md_busy}); end
        step();
        reset = 1'b1; D_is_md = 1'b0; #1;
        step();
        checks++; if ({stall, md_busy} !== 2'b00) begin errors++; $display("FAIL rm_after: got %b exp 00", {stall, md_busy}); end
        set_d(0, 4, 0, 4, 5, 3);
        step();
        set_d(5, 1, 0, 4, 6, 2);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rl_stall: got %b exp 1", stall); end
        reset = 1'b0; #1;
        checks++;
        if ({stall, fwd_D_A1_sel, fwd_D_A2_sel, fwd_E_A1_sel, fwd_E_A2_sel} !== 9'd0) begin
            errors++;
            $display("FAIL rl_clear: got %b exp 0", {stall, fwd_D_A1_sel, fwd_D_A2_sel, fwd_E_A1_sel, fwd_E_A2_sel});
        end
        #1 reset = 1'b1;
        step();
        nop();
        checks++;
        if ({stall, md_busy, fwd_D_A1_sel, fwd_D_A2_sel, fwd_E_A1_sel, fwd_E_A2_sel} !== 10'd0) begin
            errors++;
            $display("FAIL rl_after: got %b exp 0", {stall, md_busy, fwd_D_A1_sel, fwd_D_A2_sel, fwd_E_A1_sel, fwd_E_A2_sel});
        end
        step();
    endtask

    initial begin
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_load_branch();
        test_jal_zero();
        test_tuse_never();
        test_md();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1);
    end

endmodule
